// File: rtl/wdt_multi.sv
// Multi-channel watchdog timer: shared prescaler, per-channel down-counter with
// optional two-stage (warn then trip) and window (early-kick) supervision.
module wdt_multi #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [PRE_W-1:0] prescale,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_ch,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
    input  logic [N_CH-1:0]  wdt_en,
    input  logic [N_CH-1:0]  wdt_kick,
    input  logic [N_CH-1:0]  trip_clr,
    output logic [N_CH-1:0]  wdt_irq,
    output logic [N_CH-1:0]  trip,
    output logic             wto,
    output logic [CNT_W-1:0] cnt_mon
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WARN = 2'd2,
        ST_TRIP = 2'd3
    } state_t;

    logic [PRE_W-1:0] pre_cnt_r;
    logic             tick_s;

    logic [CNT_W-1:0] load_r   [N_CH];
    logic [CNT_W-1:0] warn_r   [N_CH];
    logic [CNT_W-1:0] window_r [N_CH];
    logic [N_CH-1:0]  two_stage_r;
    logic [N_CH-1:0]  win_en_r;

    state_t           state_r [N_CH];
    state_t           state_s [N_CH];
    logic [CNT_W-1:0] cnt_r   [N_CH];
    logic [CNT_W-1:0] cnt_s   [N_CH];
    logic [N_CH-1:0]  irq_s;
    logic [N_CH-1:0]  trip_s;
    logic [CNT_W-1:0] cnt_mon_s;

    // A prescale change is picked up at the very next compare.
    assign tick_s = (pre_cnt_r == prescale);

    // Shared free-running prescaler
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_cnt_r <= '0;
        end else if (tick_s) begin
            pre_cnt_r <= '0;
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_W'(1);
        end
    end

    // Shadow configuration registers; out-of-range channel indices match nothing
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_CH; i++) begin
                load_r[i]   <= '1;
                warn_r[i]   <= '1;
                window_r[i] <= '1;
            end
            two_stage_r <= '0;
            win_en_r    <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_we && (cfg_ch == 3'(i))) begin
                    case (cfg_sel)
                        2'd0: load_r[i]   <= cfg_data;
                        2'd1: warn_r[i]   <= cfg_data;
                        2'd2: window_r[i] <= cfg_data;
                        2'd3: begin
                            // mode only changes while the channel is parked
                            if (state_r[i] == ST_IDLE) begin
                                win_en_r[i]    <= cfg_data[1];
                                two_stage_r[i] <= cfg_data[0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Per-channel next-state, next-counter and output decode
    always_comb begin
        irq_s     = '0;
        trip_s    = '0;
        cnt_mon_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_s[i] = state_r[i];
            cnt_s[i]   = cnt_r[i];
            case (state_r[i])
                ST_IDLE: begin
                    if (wdt_en[i]) begin
                        state_s[i] = ST_RUN;
                        cnt_s[i]   = load_r[i];
                    end else begin
                        state_s[i] = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!wdt_en[i]) begin
                        state_s[i] = ST_IDLE;
                    end else if (wdt_kick[i]) begin
                        // early kick beats the reload
                        if (win_en_r[i] && (cnt_r[i] > window_r[i])) begin
                            state_s[i] = ST_TRIP;
                        end else begin
                            cnt_s[i] = load_r[i];
                        end
                    end else if (tick_s) begin
                        if (cnt_r[i] != '0) begin
                            cnt_s[i] = cnt_r[i] - CNT_W'(1);
                        end else if (two_stage_r[i]) begin
                            state_s[i] = ST_WARN;
                            cnt_s[i]   = warn_r[i];
                        end else begin
                            state_s[i] = ST_TRIP;
                        end
                    end else begin
                        state_s[i] = ST_RUN;
                    end
                end
                ST_WARN: begin
                    if (!wdt_en[i]) begin
                        state_s[i] = ST_IDLE;
                    end else if (wdt_kick[i]) begin
                        state_s[i] = ST_RUN;
                        cnt_s[i]   = load_r[i];
                    end else if (tick_s) begin
                        if (cnt_r[i] != '0) begin
                            cnt_s[i] = cnt_r[i] - CNT_W'(1);
                        end else begin
                            state_s[i] = ST_TRIP;
                        end
                    end else begin
                        state_s[i] = ST_WARN;
                    end
                end
                ST_TRIP: begin
                    if (trip_clr[i]) begin
                        state_s[i] = ST_IDLE;
                    end else begin
                        state_s[i] = ST_TRIP;
                    end
                end
                default: begin
                    state_s[i] = ST_IDLE;
                end
            endcase
            irq_s[i]  = (state_s[i] == ST_WARN);
            trip_s[i] = (state_s[i] == ST_TRIP);
            cnt_mon_s = cnt_mon_s | ({CNT_W{cfg_ch == 3'(i)}} & cnt_s[i]);
        end
    end

    // Channel state and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_CH; i++) begin
                state_r[i] <= ST_IDLE;
                cnt_r[i]   <= '0;
            end
            wdt_irq <= '0;
            trip    <= '0;
            wto     <= 1'b0;
            cnt_mon <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_r[i] <= state_s[i];
                cnt_r[i]   <= cnt_s[i];
            end
            wdt_irq <= irq_s;
            trip    <= trip_s;
            wto     <= |trip_s;
            cnt_mon <= cnt_mon_s;
        end
    end

endmodule

// File: tb/tb_wdt_multi.sv
// Directed bench for wdt_multi: expectations are queued as stimulus is applied
// and popped when the DUT output is sampled one time unit after the clock edge.
module tb_wdt_multi;
    localparam int N_CH  = 4;
    localparam int CNT_W = 32;
    localparam int PRE_W = 8;

    logic             clk;
    logic             rstn;
    logic [PRE_W-1:0] prescale;
    logic             cfg_we;
    logic [2:0]       cfg_ch;
    logic [1:0]       cfg_sel;
    logic [CNT_W-1:0] cfg_data;
    logic [N_CH-1:0]  wdt_en;
    logic [N_CH-1:0]  wdt_kick;
    logic [N_CH-1:0]  trip_clr;
    logic [N_CH-1:0]  wdt_irq;
    logic [N_CH-1:0]  trip;
    logic             wto;
    logic [CNT_W-1:0] cnt_mon;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    wdt_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .prescale (prescale),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .wdt_en   (wdt_en),
        .wdt_kick (wdt_kick),
        .trip_clr (trip_clr),
        .wdt_irq  (wdt_irq),
        .trip     (trip),
        .wto      (wto),
        .cnt_mon  (cnt_mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: observed %h, nothing queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        prescale = 8'd0;
        cfg_we   = 1'b0;
        cfg_ch   = 3'd0;
        cfg_sel  = 2'd0;
        cfg_data = 32'd0;
        wdt_en   = 4'b0000;
        wdt_kick = 4'b0000;
        trip_clr = 4'b0000;
        step(1);
        rstn = 1'b1;
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [1:0] sel, input logic [31:0] data);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_sel  = sel;
        cfg_data = data;
        step(1);
        cfg_we = 1'b0;
    endtask

    initial begin
        do_reset();
        rstn = 1'b0;
        step(2);
        expect_val("rst_wto", 32'd0);      compare(32'(wto));
        expect_val("rst_trip", 32'd0);     compare(32'(trip));
        expect_val("rst_irq", 32'd0);      compare(32'(wdt_irq));
        expect_val("rst_cnt_mon", 32'd0);  compare(cnt_mon);
        rstn = 1'b1;

        // single-stage expiry: load=5, prescale=0
        do_reset();
        cfg_write(3'd0, 2'd0, 32'd5);
        cfg_ch = 3'd0;
        wdt_en = 4'b0001;
        expect_val("s1_trip_cyc6", 32'd0);
        expect_val("s1_cnt_cyc6", 32'd0);
        step(6);
        compare(32'(trip));
        compare(cnt_mon);
        expect_val("s1_trip_cyc7", 32'h1);
        expect_val("s1_wto_cyc7", 32'd1);
        step(1);
        compare(32'(trip));
        compare(32'(wto));

        // trip is sticky against kick and disable, cleared by trip_clr
        wdt_kick = 4'b0001;
        wdt_en   = 4'b0000;
        expect_val("s5_trip_sticky", 32'h1);
        expect_val("s5_wto_sticky", 32'd1);
        step(1);
        compare(32'(trip));
        compare(32'(wto));
        wdt_kick = 4'b0000;
        trip_clr = 4'b0001;
        expect_val("s5_trip_clr", 32'd0);
        expect_val("s5_wto_clr", 32'd0);
        step(1);
        trip_clr = 4'b0000;
        compare(32'(trip));
        compare(32'(wto));
        // write to a non-existent channel must not land in channel 1
        cfg_write(3'd5, 2'd0, 32'h0000_1234);
        cfg_ch = 3'd1;
        wdt_en = 4'b0010;
        expect_val("s5_ch1_load_untouched", 32'hFFFF_FFFF);
        step(1);
        compare(cnt_mon);

        // two-stage: prescale=3, load=2, warn=4
        do_reset();
        cfg_write(3'd1, 2'd0, 32'd2);
        cfg_write(3'd1, 2'd1, 32'd4);
        cfg_write(3'd1, 2'd3, 32'd1);
        cfg_ch   = 3'd1;
        prescale = 8'd3;
        wdt_en   = 4'b0010;
        expect_val("s2_irq_cyc11", 32'd0);
        step(11);
        compare(32'(wdt_irq));
        expect_val("s2_irq_cyc12", 32'h2);
        expect_val("s2_cnt_warn", 32'd4);
        step(1);
        compare(32'(wdt_irq));
        compare(cnt_mon);
        expect_val("s2_trip_cyc31", 32'd0);
        step(19);
        compare(32'(trip));
        expect_val("s2_trip_cyc32", 32'h2);
        expect_val("s2_irq_cyc32", 32'd0);
        expect_val("s2_wto_cyc32", 32'd1);
        step(1);
        compare(32'(trip));
        compare(32'(wdt_irq));
        compare(32'(wto));

        // two-stage again, kicked while in WARN
        do_reset();
        cfg_write(3'd1, 2'd0, 32'd2);
        cfg_write(3'd1, 2'd1, 32'd4);
        cfg_write(3'd1, 2'd3, 32'd1);
        cfg_ch   = 3'd1;
        prescale = 8'd3;
        wdt_en   = 4'b0010;
        expect_val("s2b_irq_warn", 32'h2);
        step(12);
        compare(32'(wdt_irq));
        wdt_kick = 4'b0010;
        expect_val("s2b_irq_after_kick", 32'd0);
        expect_val("s2b_cnt_reload", 32'd2);
        step(1);
        wdt_kick = 4'b0000;
        compare(32'(wdt_irq));
        compare(cnt_mon);

        // window mode: early kick at 7 trips
        do_reset();
        cfg_write(3'd2, 2'd0, 32'd10);
        cfg_write(3'd2, 2'd2, 32'd4);
        cfg_write(3'd2, 2'd3, 32'd2);
        cfg_ch = 3'd2;
        wdt_en = 4'b0100;
        expect_val("s3_cnt_7", 32'd7);
        step(4);
        compare(cnt_mon);
        wdt_kick = 4'b0100;
        expect_val("s3_early_trip", 32'h4);
        expect_val("s3_cnt_held", 32'd7);
        step(1);
        wdt_kick = 4'b0000;
        compare(32'(trip));
        compare(cnt_mon);

        // window mode: kick at 3 is legal and reloads
        do_reset();
        cfg_write(3'd2, 2'd0, 32'd10);
        cfg_write(3'd2, 2'd2, 32'd4);
        cfg_write(3'd2, 2'd3, 32'd2);
        cfg_ch = 3'd2;
        wdt_en = 4'b0100;
        expect_val("s3b_cnt_3", 32'd3);
        step(8);
        compare(cnt_mon);
        wdt_kick = 4'b0100;
        expect_val("s3b_no_trip", 32'd0);
        expect_val("s3b_reload", 32'd10);
        step(1);
        wdt_kick = 4'b0000;
        compare(32'(trip));
        compare(cnt_mon);

        // load=0: kick coinciding with expiry tick wins, then expiry trips
        do_reset();
        cfg_write(3'd0, 2'd0, 32'd0);
        cfg_ch = 3'd0;
        wdt_en = 4'b0001;
        step(1);
        wdt_kick = 4'b0001;
        expect_val("s4_kick_no_trip", 32'd0);
        expect_val("s4_kick_no_irq", 32'd0);
        expect_val("s4_kick_cnt", 32'd0);
        step(1);
        wdt_kick = 4'b0000;
        compare(32'(trip));
        compare(32'(wdt_irq));
        compare(cnt_mon);
        expect_val("s4_expire_trip", 32'h1);
        step(1);
        compare(32'(trip));

        // asynchronous reset while channel 3 sits in WARN
        do_reset();
        cfg_write(3'd3, 2'd0, 32'd1);
        cfg_write(3'd3, 2'd1, 32'd20);
        cfg_write(3'd3, 2'd3, 32'd1);
        cfg_ch = 3'd3;
        wdt_en = 4'b1000;
        expect_val("s6_irq_warn", 32'h8);
        expect_val("s6_cnt_warn", 32'd20);
        step(3);
        compare(32'(wdt_irq));
        compare(cnt_mon);
        #2;
        rstn = 1'b0;
        #1;
        expect_val("s6_async_irq", 32'd0);
        expect_val("s6_async_trip", 32'd0);
        expect_val("s6_async_wto", 32'd0);
        expect_val("s6_async_cnt", 32'd0);
        compare(32'(wdt_irq));
        compare(32'(trip));
        compare(32'(wto));
        compare(cnt_mon);
        step(1);
        rstn = 1'b1;
        expect_val("s6_load_shadow_reset", 32'hFFFF_FFFF);
        step(1);
        compare(cnt_mon);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wdt_multi.md
Name: wdt_multi

Overview:
Parametrised multi-channel watchdog timer, the single-clock successor to the existing one-channel WDT. It sits beside the CPU as a peripheral. Each channel has a programmable timeout, an optional two-stage mode (interrupt first, then trip) and an optional window mode (a kick that comes too early is a violation). A trip drives the system reset request wto, which the top-level reset logic consumes.

Parameters:
N_CH, 4, number of independent watchdog channels (1..8)
CNT_W, 32, width of each channel down-counter and of the load/warn/window values
PRE_W, 8, width of the shared prescaler counter

Ports:
clk  input  1  system clock
rstn  input  1  reset, asynchronous, active-low
prescale  input  PRE_W  tick divider; tick every prescale+1 clk cycles
cfg_we  input  1  config write strobe (one cycle)
cfg_ch  input  3  channel index for cfg_we
cfg_sel  input  2  0=load, 1=warn, 2=window, 3=mode{win_en,two_stage} in cfg_data[1:0]
cfg_data  input  CNT_W  config write data
wdt_en  input  N_CH  per-channel enable (level)
wdt_kick  input  N_CH  per-channel kick strobe (one cycle)
trip_clr  input  N_CH  per-channel trip clear strobe
wdt_irq  output  N_CH  warning interrupt, registered
trip  output  N_CH  per-channel sticky trip flag, registered
wto  output  1  OR of trip, registered in the same cycle as trip
cnt_mon  output  CNT_W  counter of channel cfg_ch, for debug/readback

Behaviour:
- Reset values: all outputs 0; prescaler 0; counters 0; load/warn/window shadows all-ones; mode 0; all channels IDLE.
- Prescaler:
  - Free-running and shared by all channels.
  - Clears when pre_cnt==prescale; tick is a one-cycle pulse in that cycle.
  - prescale=0 gives a tick every cycle.
  - A prescale change takes effect on the next compare.
- Config writes:
  - A write takes one cycle into the shadow register of cfg_ch.
  - A running counter is unaffected until its next reload.
  - cfg_ch>=N_CH: the write is ignored.
  - Mode writes to a channel that is not IDLE are ignored.
- Per-channel FSM:
  - IDLE: counter held. wdt_en=1 -> RUN next cycle, counter=load.
  - RUN:
    - tick with counter!=0 -> counter-1.
    - tick with counter==0 -> WARN (two_stage=1, counter=warn, irq=1 next cycle) or TRIP (two_stage=0).
  - RUN kick:
    - win_en=1 and counter>window -> TRIP (early-kick violation).
    - Otherwise counter=load, no tick decrement that cycle.
  - WARN:
    - irq stays high.
    - kick -> RUN, counter=load, irq=0 next cycle. The window check is not applied in WARN.
    - tick with counter==0 -> TRIP, irq=0.
  - TRIP:
    - trip=1, wto=1, counter held.
    - trip_clr -> IDLE next cycle; a kick or wdt_en=0 is ignored (sticky).
    - If wdt_en is still 1 after the clear, the channel re-enters RUN the following cycle.
  - wdt_en=0 in RUN or WARN -> IDLE next cycle, irq=0.
- Priorities within one cycle:
  - trip_clr over everything in TRIP.
  - wdt_en=0 over kick.
  - kick over tick, so kick and expiry in the same cycle do not expire.
  - A window violation wins over kick reload.
- load=0 expires on the first tick after enable. warn=0 trips on the first tick in WARN.
- Latency: the state/output change is registered one clk after the causing input or tick.
- wto deasserts only when every trip bit is cleared.
- Channels are fully independent; the only shared resource is the prescaler.
- Counter arithmetic is unsigned CNT_W-bit with no wrap: it never decrements below 0.
- rstn asserted mid-operation clears everything asynchronously. The first tick after release occurs prescale+1 cycles later.

Test Plan:
- Prescale=0, ch0 load=5, two_stage=0, enable, no kick -> trip[0] and wto rise 7 clk after wdt_en (1 load cycle + 6 ticks); other channels 0.
- Prescale=3, ch1 load=2, warn=4, two_stage=1 -> irq[1] after 3 ticks (12 cycles), trip[1] 5 ticks later; a kick during WARN instead -> irq[1]=0 next cycle, counter=2.
- Ch2 load=10, window=4, win_en=1: kick at counter=7 -> trip[2] next cycle; kick at counter=3 -> reload to 10, no trip.
- Kick asserted in the same cycle as a tick at counter==0 (prescale=0, load=0) -> no WARN/TRIP, counter reloads to 0.
- Ch0 tripped, wdt_kick[0] and wdt_en[0]=0 -> trip stays 1; trip_clr[0] -> trip[0]=0 and wto=0 (if no other trips) next cycle; cfg_ch=5 write with N_CH=4 -> no register changes.
- rstn pulsed low while ch3 is in WARN -> irq[3]/trip/wto=0 immediately; cnt_mon=0; shadows back to all-ones.
